reg_bank_arbiter: RTL and testbench

Round-robin arbiter that shares one bank of D-flip-flop registers between NREQ requesters. Each requester issues single-beat read or write commands through a req/gnt handshake. At most one access is granted per clock. Read data returns on a shared bus one cycle after grant, tagged by a per-requester rvalid strobe. The block sits between independent control agents and a small register file of plain posedge DFFs.

---
 rtl/reg_bank_pkg.sv | 37 +++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/reg_bank_arbiter.sv | 75 +++++++
 tb/tb_reg_bank_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared helpers for the register-bank arbiter: pointer sizing and round-robin pick.
// Latency: pure combinational function, no state.
// Backpressure: not applicable; callers hold requests until granted.
package reg_bank_pkg;

    // Widest requester count supported; the pick function works on this width
    // and callers zero-extend / truncate to their own NREQ.
    localparam int MAX_NREQ = 8;
    localparam int MAX_PW   = $clog2(MAX_NREQ);

    // One-hot grant to the first requester at or after prio, wrapping modulo nreq.
    function automatic logic [MAX_NREQ-1:0] rr_pick(
        input logic [MAX_NREQ-1:0] req,
        input logic [MAX_PW-1:0]   prio,
        input int                  nreq
    );
        logic [MAX_NREQ-1:0] g;
        logic                found;
        int                  idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_NREQ; k++) begin
            if (k < nreq) begin
                idx = int'(prio) + k;
                if (idx >= nreq) begin
                    idx = idx - nreq;
                end
                if (!found && req[idx[MAX_PW-1:0]]) begin
                    g[idx[MAX_PW-1:0]] = 1'b1;
                    found              = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from req and a rotating priority pointer.
// Latency: grant is combinational in the same cycle as req; pointer moves at posedge.
// Backpressure: ungranted requesters simply wait; grant is forced low during reset.
module rr_arbiter
    import reg_bank_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]       prio;
    logic [PW-1:0]       prio_nxt;
    logic [MAX_NREQ-1:0] req_ext;
    logic [MAX_PW-1:0]   prio_ext;

    // Widen req and pointer to the package function's fixed width, then pick.
    always_comb begin
        req_ext                = '0;
        req_ext[NREQ-1:0]      = req;
        prio_ext               = '0;
        prio_ext[PW-1:0]       = prio;
        gnt                    = NREQ'(rr_pick(req_ext, prio_ext, NREQ));
        if (rst) begin
            gnt = '0;
        end
    end

    // Next pointer: one past the granted requester, unchanged when idle.
    always_comb begin
        prio_nxt = prio;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                prio_nxt = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= '0;
        end else begin
            prio <= prio_nxt;
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Shared DFF register bank with round-robin access among NREQ single-beat requesters.
// Latency: writes land at the grant edge; read data and rvalid appear 1 cycle after grant.
// Backpressure: req/gnt handshake; one access per clock, losers hold their command.
module reg_bank_arbiter
    import reg_bank_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = 3,
    parameter int DW   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [DW-1:0]      rdata
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] bank [DEPTH];
    logic          sel_any;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    // Mux the granted requester's command onto the single bank port.
    always_comb begin
        sel_any   = |gnt;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_we    = we[i];
                sel_addr  = addr[i*AW +: AW];
                sel_wdata = wdata[i*DW +: DW];
            end
        end
    end

    // Bank write and registered read response; rdata holds when no read is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++) begin
                bank[j] <= '0;
            end
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            rvalid <= '0;
            if (sel_any) begin
                if (sel_we) begin
                    bank[sel_addr] <= sel_wdata;
                end else begin
                    rdata  <= bank[sel_addr];
                    rvalid <= gnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter: directed vector table, reset corner sequence, random vs model.
// Latency: checks gnt mid-cycle, rvalid/rdata 1 time unit after each posedge.
// Backpressure: random requesters hold commands until granted, occasionally withdraw.
module tb_reg_bank_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 3;
    localparam int DW   = 8;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;

    int n_checks = 0;
    int n_fail   = 0;

    reg_bank_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: bank contents, pointer and last response.
    logic [DW-1:0]   m_bank [2**AW];
    int              m_prio;
    logic [NREQ-1:0] m_rv;
    logic [DW-1:0]   m_rd;
    logic [NREQ-1:0] last_gnt;

    function automatic logic [NREQ-1:0] model_gnt();
        logic [NREQ-1:0] g;
        int              i;
        g = '0;
        if (!rst) begin
            for (int k = 0; k < NREQ; k++) begin
                i = (m_prio + k) % NREQ;
                if (req[i] && g == '0) g[i] = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic model_update();
        logic [NREQ-1:0] g;
        g = model_gnt();
        if (rst) begin
            for (int a = 0; a < 2**AW; a++) m_bank[a] = '0;
            m_prio = 0;
            m_rv   = '0;
            m_rd   = '0;
        end else begin
            m_rv = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (g[i]) begin
                    m_prio = (i + 1) % NREQ;
                    if (we[i]) begin
                        m_bank[addr[i*AW +: AW]] = wdata[i*DW +: DW];
                    end else begin
                        m_rd = m_bank[addr[i*AW +: AW]];
                        m_rv = g;
                    end
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive every requester with the same address and data.
    task automatic drive(input bit r, input logic [NREQ-1:0] q, input logic [NREQ-1:0] w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        rst = r;
        req = q;
        we  = w;
        for (int i = 0; i < NREQ; i++) begin
            addr[i*AW +: AW]  = a;
            wdata[i*DW +: DW] = d;
        end
    endtask

    // One clock: check gnt before the edge, response after it.
    task automatic step(input string tag, input bit use_model, input logic [NREQ-1:0] eg,
                        input logic [NREQ-1:0] erv, input logic [DW-1:0] erd);
        logic [NREQ-1:0] g_exp;
        #3;
        g_exp    = use_model ? model_gnt() : eg;
        last_gnt = gnt;
        check({tag, " gnt"}, 32'(gnt), 32'(g_exp));
        @(posedge clk);
        model_update();
        #1;
        check({tag, " rvalid"}, 32'(rvalid), 32'(use_model ? m_rv : erv));
        check({tag, " rdata"},  32'(rdata),  32'(use_model ? m_rd : erd));
    endtask

    typedef struct {
        bit              r;
        logic [NREQ-1:0] q;
        logic [NREQ-1:0] w;
        logic [AW-1:0]   a;
        logic [DW-1:0]   d;
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] rv;
        logic [DW-1:0]   rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, logic [NREQ-1:0] q, logic [NREQ-1:0] w, logic [AW-1:0] a,
                                logic [DW-1:0] d, logic [NREQ-1:0] g, logic [NREQ-1:0] rv,
                                logic [DW-1:0] rd);
        vec_t v;
        v.r = r; v.q = q; v.w = w; v.a = a; v.d = d; v.g = g; v.rv = rv; v.rd = rd;
        return v;
    endfunction

    // Random requester state: command held until granted.
    bit            hold [NREQ];
    bit            h_we [NREQ];
    logic [AW-1:0] h_a  [NREQ];
    logic [DW-1:0] h_d  [NREQ];

    initial begin
        for (int a = 0; a < 2**AW; a++) m_bank[a] = '0;
        m_prio = 0;
        m_rv   = '0;
        m_rd   = '0;

        // Reset with all requesting, then single requester, pointer alignment, round robin.
        tbl.push_back(mk(1, 4'b1111, 4'b0000, 3'd0, 8'h00, 4'b0000, 4'b0000, 8'h00));
        tbl.push_back(mk(1, 4'b1111, 4'b0000, 3'd0, 8'h00, 4'b0000, 4'b0000, 8'h00));
        tbl.push_back(mk(0, 4'b0001, 4'b0000, 3'd3, 8'h00, 4'b0001, 4'b0001, 8'h00));
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 3'd5, 8'hA5, 4'b0100, 4'b0000, 8'h00));
        tbl.push_back(mk(0, 4'b0100, 4'b0000, 3'd5, 8'h00, 4'b0100, 4'b0100, 8'hA5));
        tbl.push_back(mk(0, 4'b1000, 4'b1000, 3'd0, 8'h00, 4'b1000, 4'b0000, 8'hA5));
        for (int k = 0; k < 8; k++) begin
            logic [NREQ-1:0] oh;
            oh = 4'b0001 << (k % 4);
            tbl.push_back(mk(0, 4'b1111, 4'b0000, 3'd5, 8'h00, oh, oh, 8'hA5));
        end
        // Pointer skip after a grant to requester 1.
        tbl.push_back(mk(0, 4'b0010, 4'b0000, 3'd5, 8'h00, 4'b0010, 4'b0010, 8'hA5));
        tbl.push_back(mk(0, 4'b1001, 4'b0000, 3'd5, 8'h00, 4'b1000, 4'b1000, 8'hA5));
        tbl.push_back(mk(0, 4'b1001, 4'b0000, 3'd5, 8'h00, 4'b0001, 4'b0001, 8'hA5));
        // Read-after-write across requesters, then an idle cycle.
        tbl.push_back(mk(0, 4'b0001, 4'b0001, 3'd7, 8'h3C, 4'b0001, 4'b0000, 8'hA5));
        tbl.push_back(mk(0, 4'b1000, 4'b0000, 3'd7, 8'h00, 4'b1000, 4'b1000, 8'h3C));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 3'd7, 8'h00, 4'b0000, 4'b0000, 8'h3C));

        drive(1, 4'b1111, 4'b0000, 3'd0, 8'h00);
        for (int r = 0; r < tbl.size(); r++) begin
            drive(tbl[r].r, tbl[r].q, tbl[r].w, tbl[r].a, tbl[r].d);
            step($sformatf("row%0d", r), 1'b0, tbl[r].g, tbl[r].rv, tbl[r].rd);
        end

        // Reset arriving with a read grant: no response, bank wiped.
        drive(0, 4'b0010, 4'b0010, 3'd2, 8'h11);
        step("mid_rst wr", 1'b0, 4'b0010, 4'b0000, 8'h3C);
        drive(0, 4'b0010, 4'b0000, 3'd2, 8'h00);
        step("mid_rst rd0", 1'b0, 4'b0010, 4'b0010, 8'h11);
        drive(1, 4'b0010, 4'b0000, 3'd2, 8'h00);
        step("mid_rst rst", 1'b0, 4'b0000, 4'b0000, 8'h00);
        drive(0, 4'b0010, 4'b0000, 3'd2, 8'h00);
        step("mid_rst rd1", 1'b0, 4'b0010, 4'b0010, 8'h00);

        // Random traffic against the model.
        for (int i = 0; i < NREQ; i++) hold[i] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!hold[i]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        hold[i] = 1'b1;
                        h_we[i] = ($urandom_range(2, 0) == 0);
                        h_a[i]  = AW'($urandom_range(2**AW - 1, 0));
                        h_d[i]  = DW'($urandom);
                    end
                end else if ($urandom_range(15, 0) == 0) begin
                    hold[i] = 1'b0;
                end
            end
            rst = ($urandom_range(50, 0) == 0);
            for (int i = 0; i < NREQ; i++) begin
                req[i]            = hold[i];
                we[i]             = h_we[i];
                addr[i*AW +: AW]  = h_a[i];
                wdata[i*DW +: DW] = h_d[i];
            end
            step($sformatf("rnd%0d", c), 1'b1, '0, '0, '0);
            for (int i = 0; i < NREQ; i++) begin
                if (last_gnt[i]) hold[i] = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
